// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises an external reset request, holds every channel in
// reset, then releases the channels one at a time in index order.
module rst_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic              coreclk,
  input  logic              corerst,
  input  logic              src_rstn,
  input  logic              soft_rst,
  input  logic [NUM_CH-1:0] soft_mask,
  output logic [NUM_CH-1:0] ch_rstn,
  output logic              done,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   src_sync;

  assign src_sync  = sync_q[SYNC_STAGES-1];
  assign state_dbg = state;

  always_ff @(posedge coreclk or posedge corerst) begin
    if (corerst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_rstn};
    end
  end

  always_ff @(posedge coreclk or posedge corerst) begin
    if (corerst) begin
      state   <= ST_RST;
      ch_rstn <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
    end else if (!src_sync) begin
      // A lost upstream reset overrides everything, including a pending soft reset.
      state   <= ST_RST;
      ch_rstn <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_RST: begin
          state <= ST_HOLD;
          busy  <= 1'b1;
          idx   <= '0;
          cnt   <= '0;
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            ch_rstn[0] <= 1'b1;
            cnt        <= '0;
            if (NUM_CH == 1) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= ST_GAP;
              idx   <= IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            // Masked channels are already high, so OR-ing the release bit is harmless.
            ch_rstn <= ch_rstn | (NUM_CH'(1) << idx);
            cnt     <= '0;
            if (idx == IDX_LAST) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (soft_rst) begin
            state   <= ST_HOLD;
            ch_rstn <= ch_rstn & soft_mask;
            done    <= 1'b0;
            busy    <= 1'b1;
            idx     <= '0;
            cnt     <= '0;
          end
        end
        default: begin
          state <= ST_RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: a default instance and a single-channel, one-cycle-hold
// instance share random stimulus and are scored against an elapsed-time model.
module tb_rst_sequencer;

  logic       coreclk = 1'b0;
  logic       corerst = 1'b1;
  logic       src_rstn = 1'b1;
  logic       soft_rst = 1'b0;
  logic [3:0] soft_mask = 4'b0000;

  logic [3:0] ch0;
  logic       done0, busy0;
  logic [1:0] st0;
  logic [0:0] ch1;
  logic       done1, busy1;
  logic [1:0] st1;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_q0[$];
  logic [5:0] exp_q1[$];

  rst_sequencer u_dut (
    .coreclk(coreclk), .corerst(corerst), .src_rstn(src_rstn), .soft_rst(soft_rst),
    .soft_mask(soft_mask), .ch_rstn(ch0), .done(done0), .busy(busy0), .state_dbg(st0)
  );

  rst_sequencer #(.NUM_CH(1), .HOLD_CYCLES(1)) u_dut1 (
    .coreclk(coreclk), .corerst(corerst), .src_rstn(src_rstn), .soft_rst(soft_rst),
    .soft_mask(soft_mask[0:0]), .ch_rstn(ch1), .done(done1), .busy(busy1), .state_dbg(st1)
  );

  // clock / reset
  always #5 coreclk = ~coreclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each instance is either idle in reset or running a sequence
  // that started at edge t0; every output follows from elapsed edges since then.
  logic [1:0] sync_m;
  int         edge_n;
  bit         run[2];
  int         t0[2];
  logic [3:0] msk[2];

  function automatic int p_nch(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int p_hold(input int d);
    return (d == 0) ? 16 : 1;
  endfunction

  function automatic logic [5:0] model_out(input int d, input int n);
    logic [3:0] ch;
    logic       dn;
    int         el;
    ch = 4'b0000;
    if (!run[d]) return 6'b0;
    el = n - t0[d];
    for (int k = 0; k < p_nch(d); k++)
      ch[k] = msk[d][k] || (el >= p_hold(d) + k * 8);
    dn = (el >= p_hold(d) + (p_nch(d) - 1) * 8);
    return {ch, dn, !dn};
  endfunction

  initial begin
    sync_m = 2'b00;
    edge_n = 0;
    for (int d = 0; d < 2; d++) begin
      run[d] = 1'b0; t0[d] = 0; msk[d] = 4'b0;
    end
    forever begin
      @(posedge coreclk);
      if (corerst) begin
        sync_m = 2'b00;
        edge_n = 0;
        for (int d = 0; d < 2; d++) run[d] = 1'b0;
      end else begin
        logic       ss;
        logic [5:0] pre;
        bit         dn_pre[2];
        for (int d = 0; d < 2; d++) begin
          pre = model_out(d, edge_n);
          dn_pre[d] = pre[1];
        end
        ss = sync_m[1];
        sync_m = {sync_m[0], src_rstn};
        edge_n++;
        for (int d = 0; d < 2; d++) begin
          if (!ss) begin
            run[d] = 1'b0;
          end else if (!run[d]) begin
            run[d] = 1'b1; t0[d] = edge_n; msk[d] = 4'b0;
          end else if (dn_pre[d] && soft_rst) begin
            t0[d]  = edge_n;
            msk[d] = (d == 0) ? soft_mask : {3'b000, soft_mask[0]};
          end
        end
      end
      exp_q0.push_back(model_out(0, edge_n));
      exp_q1.push_back(model_out(1, edge_n));
    end
  end

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge coreclk);
      if (exp_q0.size() > 0 && exp_q1.size() > 0) begin
        logic [5:0] e0, e1;
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        if (corerst) begin
          e0 = 6'b0; e1 = 6'b0;
        end
        check("dut4_outputs", {26'b0, ch0, done0, busy0}, {26'b0, e0});
        check("dut1_outputs", {26'b0, 3'b000, ch1, done1, busy1}, {26'b0, e1});
      end
    end
  end

  // driver tasks
  task automatic pulse_corerst(input int hold_edges);
    corerst = 1'b1;
    #1;
    check("async_rst_ch4", {28'b0, ch0}, 32'd0);
    check("async_rst_flags", {28'b0, ch1, done0, busy0, done1}, 32'd0);
    repeat (hold_edges) @(posedge coreclk);
    #2 corerst = 1'b0;
  endtask

  int rise[4];
  int done_rise, busy_rise, busy_fall, rise1, done1_rise;
  int drop_left;

  initial begin
    for (int k = 0; k < 4; k++) rise[k] = 0;
    done_rise = 0; busy_rise = 0; busy_fall = 0; rise1 = 0; done1_rise = 0;
    repeat (3) @(posedge coreclk);
    #2 corerst = 1'b0;

    // Power-up sequence; soft_rst at edge 25 lands in GAP and must be ignored,
    // then a masked soft reset is issued once the sequence is done.
    for (int i = 1; i <= 52; i++) begin
      @(posedge coreclk);
      #1;
      for (int k = 0; k < 4; k++)
        if (ch0[k] && rise[k] == 0) rise[k] = i;
      if (done0 && done_rise == 0) done_rise = i;
      if (busy0 && busy_rise == 0) busy_rise = i;
      if (!busy0 && busy_rise != 0 && busy_fall == 0) busy_fall = i;
      if (ch1[0] && rise1 == 0) rise1 = i;
      if (done1 && done1_rise == 0) done1_rise = i;
      if (i == 51) begin
        check("soft_masked_ch", {28'b0, ch0}, 32'h5);
        check("soft_masked_ch1", {31'b0, ch1}, 32'h1);
      end
      #1;
      soft_rst  = (i == 24) || (i == 50);
      soft_mask = (i == 50) ? 4'b0101 : 4'b0000;
    end
    check("rise_ch0", rise[0], 19);
    check("rise_ch1", rise[1], 27);
    check("rise_ch2", rise[2], 35);
    check("rise_ch3", rise[3], 43);
    check("done_rise", done_rise, 43);
    check("busy_rise", busy_rise, 3);
    check("busy_fall", busy_fall, 43);
    check("single_ch_rise", rise1, 4);
    check("single_done_rise", done1_rise, 4);

    // Random phase: soft resets, short src_rstn drops, occasional async corerst.
    drop_left = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge coreclk);
      #2;
      if ($urandom_range(0, 499) == 0) begin
        soft_rst = 1'b0;
        pulse_corerst($urandom_range(1, 3));
      end else begin
        soft_rst  = ($urandom_range(0, 11) == 0);
        soft_mask = 4'($urandom);
        if (drop_left > 0) drop_left--;
        else if ($urandom_range(0, 149) == 0) drop_left = $urandom_range(1, 3);
        src_rstn = (drop_left == 0);
      end
    end
    soft_rst = 1'b0;
    src_rstn = 1'b1;
    repeat (3) @(posedge coreclk);
    @(negedge coreclk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
